// File: rtl/alu_params.sv
// Opcode encodings shared by the decode/issue stage and the 8-bit ALU.
// All stages refer to opcodes only by these names.
package alu_params_pkg;
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADI  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_MUL  = 4'h5;
   localparam logic [3:0] OP_DIV  = 4'h6;
   localparam logic [3:0] OP_INC  = 4'h7;
   localparam logic [3:0] OP_DEC  = 4'h8;
   localparam logic [3:0] OP_NOR  = 4'h9;
   localparam logic [3:0] OP_NAND = 4'hA;
   localparam logic [3:0] OP_XOR  = 4'hB;
   localparam logic [3:0] OP_COMP = 4'hC;
   localparam logic [3:0] OP_CMPJ = 4'hD;
   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;
endpackage

// File: rtl/alu_issue.sv
// Decode/operand-issue stage: scoreboarded regfile read with write-back bypass, 1-cycle issue latency.
// Stalls on source/WAW hazards or a held output bundle; freezes after HALT until reset.
module alu_issue
   import alu_params_pkg::*;
#(
   parameter int NREG = 8,
   parameter int DW   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [15:0]             in_instr,
   input  logic [DW-1:0]           in_pc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DW-1:0]           alu_a,
   output logic [DW-1:0]           alu_b,
   output logic [3:0]              alu_opc,
   output logic [$clog2(NREG)-1:0] out_rd,
   output logic                    out_we,
   input  logic                    wb_en,
   input  logic [$clog2(NREG)-1:0] wb_addr,
   input  logic [DW-1:0]           wb_data,
   output logic                    halted
);
   localparam int AW = $clog2(NREG);
   localparam logic [0:0] S_RUN    = 1'b0;
   localparam logic [0:0] S_HALTED = 1'b1;

   logic [DW-1:0]   r_rf [NREG];
   logic [NREG-1:0] r_busy;
   logic [0:0]      r_state;
   logic            r_out_valid;
   logic [DW-1:0]   r_alu_a;
   logic [DW-1:0]   r_alu_b;
   logic [3:0]      r_alu_opc;
   logic [AW-1:0]   r_out_rd;
   logic            r_out_we;

   logic [3:0]      w_opc;
   logic [AW-1:0]   w_rd;
   logic [AW-1:0]   w_rs;
   logic [AW-1:0]   w_rt;
   logic [DW-1:0]   w_imm;
   logic [DW-1:0]   w_rd_val;
   logic [DW-1:0]   w_rs_val;
   logic [DW-1:0]   w_rt_val;
   logic [DW-1:0]   w_a;
   logic [DW-1:0]   w_b;
   logic            w_we;
   logic            w_use_rd;
   logic            w_use_rs;
   logic            w_use_rt;
   logic [NREG-1:0] w_wb_mask;
   logic [NREG-1:0] w_busy_eff;
   logic [NREG-1:0] w_busy_nxt;
   logic            w_hazard;
   logic            w_accept;

   assign w_opc = in_instr[15:12];
   assign w_rd  = in_instr[11:9];
   assign w_rs  = in_instr[8:6];
   assign w_rt  = in_instr[5:3];
   assign w_imm = in_instr[7:0];

   // A write-back landing this cycle is visible to the read in the same cycle.
   assign w_rd_val = (wb_en && (wb_addr == w_rd)) ? wb_data : r_rf[w_rd];
   assign w_rs_val = (wb_en && (wb_addr == w_rs)) ? wb_data : r_rf[w_rs];
   assign w_rt_val = (wb_en && (wb_addr == w_rt)) ? wb_data : r_rf[w_rt];

   always_comb begin
      w_a      = '0;
      w_b      = '0;
      w_we     = 1'b0;
      w_use_rd = 1'b0;
      w_use_rs = 1'b0;
      w_use_rt = 1'b0;
      case (w_opc)
         OP_LDI: begin
            w_b  = w_imm;
            w_we = 1'b1;
         end
         OP_ADI: begin
            w_a      = w_rd_val;
            w_b      = w_imm;
            w_we     = 1'b1;
            w_use_rd = 1'b1;
         end
         OP_INC, OP_DEC: begin
            w_a      = w_rs_val;
            w_we     = 1'b1;
            w_use_rs = 1'b1;
         end
         OP_COMP: begin
            w_b      = w_rs_val;
            w_we     = 1'b1;
            w_use_rs = 1'b1;
         end
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_NOR, OP_NAND, OP_XOR: begin
            w_a      = w_rs_val;
            w_b      = w_rt_val;
            w_we     = 1'b1;
            w_use_rs = 1'b1;
            w_use_rt = 1'b1;
         end
         OP_CMPJ: begin
            w_a      = w_rs_val;
            w_b      = w_rt_val;
            w_use_rs = 1'b1;
            w_use_rt = 1'b1;
         end
         OP_JMP: begin
            w_a = in_pc;
            w_b = w_imm;
         end
         default: ;
      endcase
   end

   assign w_wb_mask  = wb_en ? (NREG'(1) << wb_addr) : '0;
   assign w_busy_eff = r_busy & ~w_wb_mask;
   assign w_hazard   = in_valid && ((w_use_rs && w_busy_eff[w_rs]) ||
                                    (w_use_rt && w_busy_eff[w_rt]) ||
                                    ((w_use_rd || w_we) && w_busy_eff[w_rd]));
   assign in_ready   = (r_state == S_RUN) && !w_hazard && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;

   // Set after clear so an issue to the register being written back stays busy.
   always_comb begin
      w_busy_nxt = r_busy & ~w_wb_mask;
      if (w_accept && w_we) w_busy_nxt[w_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (wb_en) begin
         r_rf[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= '0;
         r_state <= S_RUN;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_accept && (w_opc == OP_HALT)) r_state <= S_HALTED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_opc   <= '0;
         r_out_rd    <= '0;
         r_out_we    <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_alu_a     <= w_a;
         r_alu_b     <= w_b;
         r_alu_opc   <= w_opc;
         r_out_rd    <= w_we ? w_rd : '0;
         r_out_we    <= w_we;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_opc   = r_alu_opc;
   assign out_rd    = r_out_rd;
   assign out_we    = r_out_we;
   assign halted    = (r_state == S_HALTED);

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_issue;
   import alu_params_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_instr = '0;
   logic [7:0]  in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [3:0]  alu_opc;
   logic [2:0]  out_rd;
   logic        out_we;
   logic        wb_en = 1'b0;
   logic [2:0]  wb_addr = '0;
   logic [7:0]  wb_data = '0;
   logic        halted;

   always #5 clk = ~clk;

   alu_issue dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opc(alu_opc), .out_rd(out_rd), .out_we(out_we),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .halted(halted)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference state: architectural registers, pending writers, and the issued bundle.
   logic [7:0] m_rf [8];
   bit   [7:0] m_busy;
   bit         m_halt, m_ov, m_we;
   logic [7:0] m_a, m_b;
   logic [3:0] m_opc;
   logic [2:0] m_rd;

   function automatic void m_reset();
      for (int r = 0; r < 8; r++) m_rf[r] = 8'h00;
      m_busy = '0; m_halt = 0; m_ov = 0; m_we = 0;
      m_a = '0; m_b = '0; m_opc = '0; m_rd = '0;
   endfunction

   function automatic bit writes(input logic [3:0] op);
      return op inside {OP_LDI, OP_ADI, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
                        OP_INC, OP_DEC, OP_NOR, OP_NAND, OP_XOR, OP_COMP};
   endfunction

   function automatic bit [7:0] need_mask(input logic [15:0] ins);
      bit [7:0] m = '0;
      case (ins[15:12])
         OP_ADI:                   m[ins[11:9]] = 1'b1;
         OP_INC, OP_DEC, OP_COMP:  m[ins[8:6]]  = 1'b1;
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_NOR, OP_NAND, OP_XOR, OP_CMPJ: begin
            m[ins[8:6]] = 1'b1;
            m[ins[5:3]] = 1'b1;
         end
         default: ;
      endcase
      if (writes(ins[15:12])) m[ins[11:9]] = 1'b1;
      return m;
   endfunction

   function automatic logic [7:0] rd_reg(input logic [2:0] r);
      return (wb_en && wb_addr == r) ? wb_data : m_rf[r];
   endfunction

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
      return {op, rd, rs, rt, 3'b000};
   endfunction

   function automatic logic [15:0] mki(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [7:0] imm);
      return {op, rd, 1'b0, imm};
   endfunction

   // One clock: compare at the falling edge, advance the model at the rising edge.
   // Must be entered just after a rising edge.
   task automatic cycle();
      bit [7:0]   eff;
      bit         rdy, acc, wr;
      logic [7:0] a, b;
      logic [3:0] op;
      logic [2:0] rd, rs, rt;
      @(negedge clk);
      op = in_instr[15:12]; rd = in_instr[11:9]; rs = in_instr[8:6]; rt = in_instr[5:3];
      for (int r = 0; r < 8; r++) eff[r] = m_busy[r] && !(wb_en && wb_addr == 3'(r));
      rdy = !m_halt && !(in_valid && ((need_mask(in_instr) & eff) != 0)) && (!m_ov || out_ready);
      check("in_ready", in_ready, rdy);
      check("out_valid", out_valid, m_ov);
      check("halted", halted, m_halt);
      check("bundle", {alu_a, alu_b, alu_opc, out_rd, out_we}, {m_a, m_b, m_opc, m_rd, m_we});
      acc = in_valid && rdy;
      wr  = writes(op);
      case (op)
         OP_LDI:                begin a = 8'h00;       b = in_instr[7:0]; end
         OP_ADI:                begin a = rd_reg(rd);  b = in_instr[7:0]; end
         OP_INC, OP_DEC:        begin a = rd_reg(rs);  b = 8'h00;         end
         OP_COMP:               begin a = 8'h00;       b = rd_reg(rs);    end
         OP_JMP:                begin a = in_pc;       b = in_instr[7:0]; end
         OP_NOP, OP_HALT:       begin a = 8'h00;       b = 8'h00;         end
         default:               begin a = rd_reg(rs);  b = rd_reg(rt);    end
      endcase
      @(posedge clk);
      if (acc) begin
         m_ov = 1; m_a = a; m_b = b; m_opc = op; m_we = wr; m_rd = wr ? rd : 3'd0;
         if (op == OP_HALT) m_halt = 1;
      end else if (out_ready) begin
         m_ov = 0;
      end
      if (wb_en) begin
         m_busy[wb_addr] = 1'b0;
         m_rf[wb_addr]   = wb_data;
      end
      if (acc && wr) m_busy[rd] = 1'b1;
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] ins;
      logic [3:0]  op;
      m_reset();
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_bundle", {alu_a, alu_b, alu_opc, out_rd, out_we}, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // LDI rd=2 imm=0x5A
      out_ready = 1; in_valid = 1; in_instr = mki(OP_LDI, 3'd2, 8'h5A);
      cycle();
      check("t1_bundle", {out_valid, alu_a, alu_b, alu_opc, out_rd, out_we},
            {1'b1, 8'h00, 8'h5A, OP_LDI, 3'd2, 1'b1});
      in_instr = mk(OP_INC, 3'd0, 3'd2, 3'd0);
      #1 check("t1_busy2", in_ready, 0);

      // write back R1, R2 then ADD r3 = r1, r2
      in_valid = 0; wb_en = 1; wb_addr = 3'd1; wb_data = 8'h10;
      cycle();
      wb_addr = 3'd2; wb_data = 8'h03;
      cycle();
      wb_en = 0; in_valid = 1; in_instr = mk(OP_ADD, 3'd3, 3'd1, 3'd2);
      cycle();
      check("t2_bundle", {alu_a, alu_b, alu_opc, out_rd, out_we},
            {8'h10, 8'h03, OP_ADD, 3'd3, 1'b1});

      // RAW on r4 resolved by a bypassed write-back
      in_instr = mk(OP_INC, 3'd4, 3'd1, 3'd0);
      cycle();
      in_instr = mk(OP_SUB, 3'd5, 3'd4, 3'd1);
      cycle();
      check("t3_stall", in_ready, 0);
      cycle();
      wb_en = 1; wb_addr = 3'd4; wb_data = 8'h11;
      #1 check("t3_unblock", in_ready, 1);
      cycle();
      wb_en = 0; in_valid = 0;
      check("t3_bundle", {alu_a, alu_b, alu_opc, out_rd}, {8'h11, 8'h10, OP_SUB, 3'd5});

      // backpressure
      cycle();
      out_ready = 0; in_valid = 1; in_instr = mki(OP_LDI, 3'd6, 8'h77);
      cycle();
      in_instr = mki(OP_LDI, 3'd7, 8'h33);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("t4_hold", {out_valid, alu_b, out_rd, in_ready}, {1'b1, 8'h77, 3'd6, 1'b0});
      end
      out_ready = 1;
      cycle();
      in_valid = 0;
      check("t4_second", {out_valid, alu_b, out_rd}, {1'b1, 8'h33, 3'd7});
      cycle();
      check("t4_drain", out_valid, 0);

      // random traffic, HALT excluded
      for (int n = 0; n < 1500; n++) begin
         ins = 16'($urandom());
         op  = 4'($urandom_range(0, 14));
         ins[15:12] = op;
         in_instr  = ins;
         in_pc     = 8'($urandom());
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         wb_en     = ($urandom_range(0, 2) == 0);
         wb_addr   = 3'($urandom());
         if (m_busy != 0 && $urandom_range(0, 1) == 1)
            while (!m_busy[wb_addr]) wb_addr = wb_addr + 3'd1;
         wb_data   = 8'($urandom());
         cycle();
      end

      // clear all pending writers
      in_valid = 0; out_ready = 1; wb_en = 1;
      for (int r = 0; r < 8; r++) begin
         wb_addr = 3'(r); wb_data = 8'($urandom());
         cycle();
      end
      wb_en = 0;

      // JMP then HALT
      in_valid = 1; in_instr = mki(OP_LDI, 3'd5, 8'h42);
      cycle();
      in_instr = mki(OP_JMP, 3'd0, 8'h04); in_pc = 8'h20;
      cycle();
      check("t5_jmp", {alu_a, alu_b, alu_opc, out_rd, out_we}, {8'h20, 8'h04, OP_JMP, 3'd0, 1'b0});
      in_instr = mk(OP_HALT, 3'd0, 3'd0, 3'd0);
      cycle();
      check("t5_halt", {out_valid, alu_opc, halted}, {1'b1, OP_HALT, 1'b1});
      out_ready = 0; in_instr = mki(OP_LDI, 3'd6, 8'h01);
      for (int k = 0; k < 12; k++) begin
         cycle();
         check("t5_frozen", {halted, in_ready, out_valid}, {1'b1, 1'b0, 1'b1});
      end

      // asynchronous reset mid-stall
      in_instr = mki(OP_ADI, 3'd5, 8'h01);
      #1 check("t6_pre", in_ready, 0);
      #1 rst_n = 0;
      #1;
      check("t6_out_valid", out_valid, 0);
      check("t6_halted", halted, 0);
      check("t6_bundle", {alu_a, alu_b, alu_opc, out_rd, out_we}, 0);
      check("t6_busy_clear", in_ready, 1);
      @(negedge clk);
      rst_n = 1; in_valid = 0; m_reset();
      @(posedge clk); #1;
      out_ready = 1; in_valid = 1;
      for (int r = 0; r < 8; r++) begin
         in_instr = mk(OP_CMPJ, 3'd0, 3'(r), 3'(r));
         cycle();
         check("t6_reg_zero", {out_valid, alu_a, alu_b}, {1'b1, 8'h00, 8'h00});
      end
      in_valid = 0;
      cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/operand-issue stage directly upstream of the 8-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and reads an internal 8x8 register file.
- Resolves register hazards with a scoreboard and write-back bypass.
- Drives a registered alu_a/alu_b/alu_opc bundle plus destination info to the execute stage. Write-back returns on a dedicated write port.

Parameters:
- NREG, 8, number of architectural registers (address width = 3)
- DW, 8, data width of registers, operands and immediates

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_instr  in  16  [15:12] opc, [11:9] rd, [8:6] rs, [5:3] rt, [7:0] imm8 (imm overlaps rs/rt)
- in_pc  in  8  PC of in_instr
- out_valid  out  1  issued bundle valid
- out_ready  in  1  execute stage consumes bundle
- alu_a  out  8  operand A
- alu_b  out  8  operand B
- alu_opc  out  4  opcode
- out_rd  out  3  destination register
- out_we  out  1  bundle writes out_rd at write-back
- wb_en  in  1  write-back strobe
- wb_addr  in  3  write-back register
- wb_data  in  8  write-back value
- halted  out  1  HALT issued; stage frozen

Behaviour:
- Opcode values and names come from the shared ALU parameter include (alu_params.sv). The stage decodes by name.
- Operand select (R[x] = register read after bypass):
  - LDI: a=0, b=imm8
  - ADI: a=R[rd], b=imm8
  - INC/DEC: a=R[rs], b=0
  - COMP: a=0, b=R[rs]
  - ADD/SUB/Mul/Div/NOR/NAND/XOR/CMPJ: a=R[rs], b=R[rt]
  - JMP: a=in_pc, b=imm8
  - NOP/HALT: a=0, b=0
- out_we=1 for LDI, ADI, ADD, SUB, Mul, Div, INC, DEC, NOR, NAND, XOR, COMP. out_we=0 otherwise, with out_rd=0.
- Register file: flops, all cleared on reset. wb_en writes wb_data to R[wb_addr] at the clock edge.
- Bypass: a same-cycle read of wb_addr while wb_en=1 returns wb_data.
- Scoreboard: NREG busy bits.
  - An issue with out_we=1 sets busy[rd].
  - wb_en clears busy[wb_addr].
  - Simultaneous set and clear of the same bit: set wins.
- Effective busy = busy & ~(wb_en ? onehot(wb_addr) : 0). A clearing write-back therefore unblocks the same cycle via bypass.
- hazard = in_valid && (any source used by the opcode is effectively busy, or out_we-op with busy rd (WAW)).
- in_ready = (state==RUN) && !hazard && (!out_valid || out_ready). It is combinational, with no dependency on in_valid except through the hazard term.
- Accept = in_valid && in_ready. On accept, the output bundle registers load next edge and out_valid=1. Latency is 1 cycle.
- When out_valid && out_ready && !accept, out_valid clears next edge. Output fields hold while out_valid && !out_ready.
- FSM: RUN -> HALTED on accept of HALT.
  - The HALT bundle is still issued (out_valid=1, opc=HALT).
  - In HALTED: in_ready=0 permanently and halted=1. The scoreboard and write-back still update. Exit is by reset only.
- Reset (async, any time, including mid-stall or with a bundle held):
  - out_valid=0, alu_a=0, alu_b=0, alu_opc=0, out_rd=0, out_we=0, halted=0
  - scoreboard all 0, regfile all 0, state RUN
  - in_ready evaluates from the reset state.
- Arithmetic: none in this stage. All fields are pass-through or selected; no width extension beyond 8 bits.
- Unused instruction fields are ignored.
- wb_en to a register that is not busy is legal and updates it.

Test Plan:
1. Reset, then LDI rd=2 imm=0x5A with out_ready=1 -> next cycle out_valid=1, a=0x00, b=0x5A, opc=LDI, out_rd=2, out_we=1, busy[2]=1.
2. Write-back R1=0x10 and R2=0x03, then ADD rd=3 rs=1 rt=2 -> a=0x10, b=0x03, out_we=1, rd=3.
3. RAW: issue INC rd=4 rs=1, then SUB rs=4 rt=1 -> in_ready=0 until wb_en addr=4 data=0x11. In that same cycle in_ready=1, and the issued bundle has a=0x11 via bypass.
4. Backpressure: out_ready=0 with two instructions offered -> first bundle held stable, in_ready=0. With out_ready=1, the second issues the next cycle with no loss or duplication.
5. JMP with in_pc=0x20 imm=0x04, then HALT -> a=0x20, b=0x04, out_we=0. The HALT bundle is issued, then halted=1 and in_ready=0 for 10+ cycles despite in_valid=1.
6. Assert rst_n low mid-stall with busy bits set and out_valid=1 -> out_valid, halted and the busy bits drop immediately, without waiting for a clock edge. After release, the register reads return 0.
